// File: rtl/arm_multicycle_control.sv
// Multicycle ARM control: Moore FSM, DP decode, flag register and CondEx.
// Optional memory wait states when MEM_WAIT_EN is defined.
module arm_multicycle_control #(
  parameter int ALUCTRL_W = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [31:12]         Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [ALUCTRL_W-1:0] A_ADD = ALUCTRL_W'(2'd0);
  localparam logic [ALUCTRL_W-1:0] A_SUB = ALUCTRL_W'(2'd1);
  localparam logic [ALUCTRL_W-1:0] A_AND = ALUCTRL_W'(2'd2);
  localparam logic [ALUCTRL_W-1:0] A_ORR = ALUCTRL_W'(2'd3);

  state_t               st;
  logic [3:0]           flags;
  logic                 condex;
  logic                 mrdy;
  logic [1:0]           op;
  logic [3:0]           cmd;
  logic [ALUCTRL_W-1:0] dp_alu;
  logic                 nowrite;
  logic [1:0]           flagw;
  logic                 unused_rn;

  assign op        = Instr[27:26];
  assign cmd       = Instr[24:21];
  assign ImmSrc    = Instr[27:26];
  assign RegSrc    = {op == 2'b01, op == 2'b10};
  assign State     = st;
  assign unused_rn = ^Instr[19:16];

`ifdef MEM_WAIT_EN
  assign mrdy = MemReady;
`else
  logic unused_mready;
  assign unused_mready = MemReady;
  assign mrdy = 1'b1;
`endif

  always_comb begin
    dp_alu  = A_ADD;
    nowrite = 1'b0;
    flagw   = 2'b00;
    case (cmd)
      4'b0100: begin
        dp_alu = A_ADD;
        flagw  = {2{Instr[20]}};
      end
      4'b0010: begin
        dp_alu = A_SUB;
        flagw  = {2{Instr[20]}};
      end
      4'b0000: begin
        dp_alu = A_AND;
        flagw  = {Instr[20], 1'b0};
      end
      4'b1100: begin
        dp_alu = A_ORR;
        flagw  = {Instr[20], 1'b0};
      end
      4'b1010: begin
        dp_alu  = A_SUB;
        nowrite = 1'b1;
        flagw   = 2'b11;
      end
      default: begin
        dp_alu  = A_ADD;
        nowrite = 1'b1;
        flagw   = {Instr[20], 1'b0};
      end
    endcase
  end

  // flags = {N, Z, C, V}
  always_comb begin
    case (Instr[31:28])
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = flags[3] == flags[0];
      4'b1011: condex = flags[3] != flags[0];
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      st    <= FETCH;
      flags <= 4'b0000;
    end else begin
      if ((st == EXECR || st == EXECI) && condex) begin
        if (flagw[1]) flags[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags[1:0] <= ALUFlags[1:0];
      end
      case (st)
        FETCH:  if (mrdy) st <= DECODE;
        DECODE: begin
          case (op)
            2'b01:   st <= MEMADR;
            2'b00:   st <= Instr[25] ? EXECI : EXECR;
            2'b10:   st <= BRANCH;
            default: st <= FETCH;
          endcase
        end
        MEMADR: st <= Instr[20] ? MEMRD : MEMWR;
        MEMRD:  if (mrdy) st <= MEMWB;
        MEMWR:  if (mrdy) st <= FETCH;
        EXECR:  st <= ALUWB;
        EXECI:  st <= ALUWB;
        default: st <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = A_ADD;
    RegWrite   = 1'b0;
    case (st)
      FETCH: begin
        IRWrite   = mrdy;
        PCWrite   = mrdy;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = Instr[23] ? A_ADD : A_SUB;
      end
      MEMRD:  AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex & mrdy;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex;
      end
      EXECR:  ALUControl = dp_alu;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      ALUWB: begin
        if (Instr[15:12] == 4'd15) PCWrite = condex & ~nowrite;
        else RegWrite = condex & ~nowrite;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex;
      end
      default: ;
    endcase
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_control.sv
// Scoreboard bench for arm_multicycle_control: driver queues expected
// per-cycle outputs, a negedge monitor pops and compares.
module tb_arm_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:12] Instr = '0;
  logic [3:0]  ALUFlags = 4'hF;
  logic        MemReady = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic        ALUSrcA, RegWrite;
  logic [5:0]  ALUControl;
  logic [3:0]  State;

  arm_multicycle_control #(.ALUCTRL_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mw, rw;
    logic [1:0] rs;
    logic       sa;
    logic [1:0] sb;
    logic       adr;
    logic [5:0] alu;
    logic [1:0] imm, rsrc;
  } obs_t;

  obs_t  expq[$];
  string nmq[$];
  int    ncmp = 0;
  int    nbad = 0;
  logic [1:0] cimm = 2'b00;
  logic [1:0] crs  = 2'b00;

  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      obs_t  e, a;
      string n;
      e = expq.pop_front();
      n = nmq.pop_front();
      a = '{State, PCWrite, IRWrite, MemWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, AdrSrc, ALUControl, ImmSrc, RegSrc};
      ncmp++;
      if (a !== e) begin
        nbad++;
        $display("FAIL %s: got st=%0d pcw%b irw%b mw%b rw%b rs%b sa%b sb%b adr%b alu%0d imm%b rsrc%b, want st=%0d pcw%b irw%b mw%b rw%b rs%b sa%b sb%b adr%b alu%0d imm%b rsrc%b",
          n, a.st, a.pcw, a.irw, a.mw, a.rw, a.rs, a.sa, a.sb, a.adr,
          a.alu, a.imm, a.rsrc, e.st, e.pcw, e.irw, e.mw, e.rw, e.rs,
          e.sa, e.sb, e.adr, e.alu, e.imm, e.rsrc);
      end
    end
  end

  task automatic cy(input string n, input logic [3:0] st,
                    input logic pcw, input logic irw, input logic mw,
                    input logic rw, input logic [1:0] rs, input logic sa,
                    input logic [1:0] sb, input logic adr,
                    input logic [5:0] alu, input logic [3:0] fl = 4'hF);
    ALUFlags = fl;
    expq.push_back('{st, pcw, irw, mw, rw, rs, sa, sb, adr, alu, cimm, crs});
    nmq.push_back(n);
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [1:0] imm,
                       input logic [1:0] rsrc);
    Instr = ins[31:12];
    cimm  = imm;
    crs   = rsrc;
  endtask

  task automatic fe(input string n);
    cy(n, 4'd0, 1, 1, 0, 0, 2'b10, 1, 2'b10, 0, 6'd0);
  endtask

  task automatic de(input string n);
    cy(n, 4'd1, 0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 6'd0);
  endtask

  task automatic rst_cyc(input string n);
    cy(n, 4'd0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 6'd0);
  endtask

  task automatic dp(input string n, input logic [31:0] ins,
                    input logic [3:0] exst, input logic [1:0] sb,
                    input logic [5:0] alu, input logic [3:0] fl,
                    input logic pcw, input logic rw);
    issue(ins, 2'b00, 2'b00);
    fe({n, " fetch"});
    de({n, " decode"});
    cy({n, " exec"}, exst, 0, 0, 0, 0, 2'b00, 0, sb, 0, alu, fl);
    cy({n, " aluwb"}, 4'd8, pcw, 0, 0, rw, 2'b00, 0, 2'b00, 0, 6'd0);
  endtask

  task automatic br(input string n, input logic pcw);
    issue(32'hCA000000, 2'b10, 2'b01);
    fe({n, " fetch"});
    de({n, " decode"});
    cy({n, " branch"}, 4'd9, pcw, 0, 0, 0, 2'b10, 0, 2'b01, 0, 6'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge CLK);
    #1;
    rst_cyc("reset0");
    rst_cyc("reset1");
    Reset = 1'b0;

    dp("SUBS", 32'hE0511000, 4'd6, 2'b00, 6'd1, 4'b0110, 0, 1);
    dp("ADDEQ", 32'h02822000, 4'd7, 2'b01, 6'd0, 4'hF, 0, 1);
    dp("ADDNE", 32'h12822000, 4'd7, 2'b01, 6'd0, 4'hF, 0, 0);
    dp("AND", 32'hE0033000, 4'd6, 2'b00, 6'd2, 4'hF, 0, 1);
    dp("EOR", 32'hE0233000, 4'd6, 2'b00, 6'd0, 4'hF, 0, 0);
    dp("ORRpc", 32'hE38FF000, 4'd7, 2'b01, 6'd3, 4'hF, 1, 0);

    issue(32'hE5804000, 2'b01, 2'b10);
    fe("STR fetch");
    de("STR decode");
    cy("STR memadr", 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 6'd0);
    cy("STR memwr", 4'd5, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 6'd0);

    dp("CMP1", 32'hE1410000, 4'd6, 2'b00, 6'd1, 4'b1001, 0, 0);
    br("BGT taken", 1);
    dp("CMP2", 32'hE1410000, 4'd6, 2'b00, 6'd1, 4'b1111, 0, 0);
    br("BGT not", 0);

    issue(32'hEC000000, 2'b11, 2'b00);
`ifdef MEM_WAIT_EN
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) rst_cyc("fetch wait");
    MemReady = 1'b1;
`endif
    fe("NOP fetch");
    de("NOP decode");

    issue(32'hE5113000, 2'b01, 2'b10);
    fe("LDR fetch");
    de("LDR decode");
    cy("LDR memadr", 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 6'd1);
    cy("LDR memrd", 4'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 6'd0);
    cy("LDR memwb", 4'd4, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 6'd0);

    fe("LDR2 fetch");
    de("LDR2 decode");
    cy("LDR2 memadr", 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 6'd1);
    cy("LDR2 memrd", 4'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 6'd0);
    Reset = 1'b1;
    rst_cyc("async reset in memwb");
    rst_cyc("reset held");
    Reset = 1'b0;

    dp("ADDCC", 32'h32822000, 4'd7, 2'b01, 6'd0, 4'hF, 0, 1);
    dp("ADDEQ post", 32'h02822000, 4'd7, 2'b01, 6'd0, 4'hF, 0, 0);

    for (int i = 0; i < 3 && expq.size() > 0; i++) @(negedge CLK);
    #1;
    if (expq.size() != 0) begin
      nbad++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
